// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine: streams two WIDTH-bit operands LSB-first through one
// full-adder cell and returns result, carry-out and signed overflow over valid/ready.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic             cout_r;
  logic             ovf_r;
  logic [CW-1:0]    count_r;
  logic             fa_sum_s;
  logic             fa_cout_s;
  logic             last_bit_s;

  // One-bit full-adder cell: returns {cout, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    logic s_v;
    logic co_v;
    s_v  = a ^ b ^ c;
    co_v = (a & b) | (a & c) | (b & c);
    return {co_v, s_v};
  endfunction

  // Full-adder cell fed from the operand shift-register LSBs and the carry flop.
  always_comb begin
    {fa_cout_s, fa_sum_s} = full_add(a_sh_r[0], b_sh_r[0], carry_r);
    last_bit_s            = (count_r == CW'(WIDTH - 1));
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_valid) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_bit_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand shifters, carry flop, result shifter and flags; subtraction is A + ~B + 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      count_r <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start_valid) begin
            a_sh_r  <= op_a;
            b_sh_r  <= sub ? ~op_b : op_b;
            carry_r <= sub;
            count_r <= {CW{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
          end
        end
        RUN: begin
          a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
          res_r   <= {fa_sum_s, res_r[WIDTH-1:1]};
          carry_r <= fa_cout_s;
          count_r <= count_r + CW'(1);
          // On the MSB, carry_r is the carry into the sign bit.
          if (last_bit_s) begin
            cout_r <= fa_cout_s;
            ovf_r  <= carry_r ^ fa_cout_s;
          end
        end
        DONE: begin
          count_r <= count_r;
        end
        default: begin
          count_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Handshake and status decode from registered state only.
  always_comb begin
    start_ready = (state_r == IDLE) & rst_n;
    res_valid   = (state_r == DONE);
    busy        = (state_r == RUN) | (state_r == DONE);
    res         = res_r;
    cout        = cout_r;
    ovf         = ovf_r;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial add/subtract engine built around the team's 1-bit full-adder cell (sum = a^b^c, cout = majority(a,b,c)).
- Accepts two WIDTH-bit operands over a valid/ready handshake and shifts them LSB-first through one full-adder cell, one bit per clock.
- Holds the carry in a flip-flop between bits, assembles the result in a shift register, and presents result plus flags over a second valid/ready handshake.
- Serves as the area-minimal adder path of the ALU. It sits directly upstream of the full-adder cell (drives a, b, c) and downstream of it (consumes sum, cout).

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start_valid  input  1  operands and mode valid
start_ready  output  1  block can accept an operation
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
sub  input  1  0 = A+B, 1 = A-B
res  output  WIDTH  result
cout  output  1  final carry out (sub: 1 = no borrow)
ovf  output  1  two's-complement signed overflow
res_valid  output  1  result/flags valid
res_ready  input  1  consumer accepts result
busy  output  1  high in RUN and DONE

Behaviour:
- Reset: rst_n sampled low at a rising edge sets the following:
  - state = IDLE
  - res = 0, cout = 0, ovf = 0, res_valid = 0, busy = 0
  - bit counter = 0, carry flop = 0, operand shift registers = 0
- start_ready = (state==IDLE) & rst_n, so it reads 0 while rst_n is low.
- Reset has priority over every other event, including mid-RUN and in DONE. Any in-flight operation is discarded; no result is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Acceptance occurs when start_valid & start_ready are high at an edge.
  - On acceptance, load a_sh = op_a and b_sh = sub ? ~op_b : op_b.
  - Also set carry = sub, count = 0, res = 0, cout = 0, ovf = 0, then go to RUN.
  - op_a, op_b and sub are sampled only at acceptance; later changes are ignored.
- RUN: one bit per edge.
  - Full-adder inputs are a = a_sh[0], b = b_sh[0], c = carry.
  - Shift a_sh and b_sh right by 1.
  - Shift res right by 1, inserting the full-adder sum at res[WIDTH-1].
  - carry <= full-adder cout; count <= count+1.
- Last bit (count == WIDTH-1):
  - cout <= full-adder cout.
  - ovf <= carry (carry into MSB) XOR full-adder cout.
  - Go to DONE.
- DONE:
  - res_valid = 1; res, cout and ovf are held stable.
  - On res_ready high at an edge: res_valid <= 0, go to IDLE. Outputs keep their values until the next acceptance.
  - start_valid is ignored, since start_ready = 0.
- Latency:
  - Acceptance at edge E0 leads to res_valid high after edge E(WIDTH), i.e. exactly WIDTH cycles.
  - Minimum initiation interval is WIDTH+2 cycles (the extra cycles are the DONE handshake and the IDLE accept).
- No combinational path from start_valid/res_ready to any output. start_ready, res_valid and busy decode registered state only.
- Width rules:
  - Internal counter width is clog2(WIDTH)+1; it must not wrap before WIDTH.
  - All arithmetic is modulo 2^WIDTH.
- Boundary behaviour:
  - All-ones + 1 wraps to 0 with cout = 1.
  - sub with op_b = 0 gives res = op_a, cout = 1, ovf = 0.
  - res_ready held high continuously gives a one-cycle DONE.
  - res_ready asserted outside DONE has no effect.

Test Plan (WIDTH=8):
- add 0x0F+0x01 -> res=0x10, cout=0, ovf=0; res_valid rises exactly 8 cycles after acceptance; busy high through RUN/DONE.
- add 0x7F+0x01 -> res=0x80, cout=0, ovf=1; add 0xFF+0x01 -> res=0x00, cout=1, ovf=0.
- sub 0x05-0x07 -> res=0xFE, cout=0, ovf=0; sub 0x80-0x01 -> res=0x7F, cout=1, ovf=1; sub 0x33-0x00 -> res=0x33, cout=1, ovf=0.
- Backpressure and sampling:
  - hold res_ready=0 for 5 cycles in DONE -> res/flags stable and start_ready=0.
  - pulse start_valid with new operands during DONE -> ignored.
  - raise res_ready -> IDLE next cycle, start_ready=1.
  - change op_a/op_b during RUN -> result unaffected.
- Reset mid-operation:
  - assert rst_n=0 at RUN bit 3 -> next edge: IDLE, res=0, cout=0, ovf=0, res_valid=0, busy=0, start_ready=0 while rst_n low.
  - release reset, run 0x12+0x34 -> res=0x46.
- Back-to-back: 50 random add/sub operations with random start_valid/res_ready gaps -> each result matches (op_a ± op_b) mod 256 with correct cout/ovf; no operation lost or duplicated.
